// File: rtl/tt_mask_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tt_mask_unpacker
// Summary  : Buffers 64-bit mask words arriving on a credit-based push
//            interface and serialises them into one mask bit per element on
//            a ready/valid stream. Returns one credit per consumed or
//            discarded word.
// Revision : 1.0 - initial release
// ============================================================================
module tt_mask_unpacker #(
  parameter int VLEN         = 256,
  parameter int MASK_CREDITS = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [$clog2(VLEN+1)-1:0] i_vl,
  input  logic [64:0]               i_mask_idx_item,
  input  logic                      i_mask_idx_valid,
  output logic                      o_mask_idx_credit,
  output logic                      o_elem_valid,
  input  logic                      i_elem_ready,
  output logic                      o_elem_mask,
  output logic [$clog2(VLEN)-1:0]   o_elem_idx,
  output logic                      o_elem_last,
  output logic                      o_busy,
  output logic                      o_overflow
);

  localparam int VL_W  = $clog2(VLEN + 1);
  localparam int IDX_W = $clog2(VLEN);
  localparam int PTR_W = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;
  localparam int CNT_W = $clog2(MASK_CREDITS + 1);

  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(MASK_CREDITS - 1);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(MASK_CREDITS);
  localparam logic [VL_W-1:0]  C_VL_ONE   = VL_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e           state_q;
  logic [63:0]      fifo_q [MASK_CREDITS];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [VL_W-1:0]  vl_q;
  logic [VL_W-1:0]  elem_cnt_q;
  logic [5:0]       bit_ptr_q;
  logic             credit_q;
  logic             overflow_q;

  logic             w_full;
  logic             w_nonempty;
  logic             w_valid;
  logic             w_hs;
  logic             w_last;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [63:0]      w_head;

  // Bit 64 of the item carries nothing this block needs.
  logic             unused_item_msb;
  assign unused_item_msb = i_mask_idx_item[64];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full     = (count_q == C_DEPTH);
  assign w_nonempty = (count_q != '0);
  assign w_head     = fifo_q[rd_ptr_q];
  assign w_last     = (elem_cnt_q == vl_q - C_VL_ONE);
  assign w_valid    = (state_q == S_RUN) && w_nonempty;
  assign w_hs       = w_valid && i_elem_ready;

  // A word retires after its 64th bit or after the final element of the op;
  // in DISCARD the single word sent for a zero-length op is dropped unread.
  assign w_pop  = (w_hs && ((bit_ptr_q == 6'd63) || w_last)) ||
                  ((state_q == S_DISCARD) && w_nonempty);
  // A pop in the same cycle frees the slot, so a push at full is still legal.
  assign w_push = i_mask_idx_valid && (!w_full || w_pop);
  assign w_drop = i_mask_idx_valid && w_full && !w_pop;

  assign o_elem_valid      = w_valid;
  assign o_elem_mask       = w_valid & w_head[bit_ptr_q];
  assign o_elem_idx        = elem_cnt_q[IDX_W-1:0];
  assign o_elem_last       = w_valid & w_last;
  assign o_busy            = (state_q != S_IDLE);
  assign o_overflow        = overflow_q;
  assign o_mask_idx_credit = credit_q;

  // Word storage; contents are only observed through a valid head pointer.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= i_mask_idx_item[63:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (w_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Element sequencer: start capture, per-element stepping, op completion.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      vl_q       <= '0;
      elem_cnt_q <= '0;
      bit_ptr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            vl_q       <= i_vl;
            elem_cnt_q <= '0;
            bit_ptr_q  <= '0;
            state_q    <= (i_vl != '0) ? S_RUN : S_DISCARD;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            elem_cnt_q <= elem_cnt_q + C_VL_ONE;
            if (w_last) begin
              bit_ptr_q <= '0;
              state_q   <= S_IDLE;
            end else begin
              bit_ptr_q <= bit_ptr_q + 6'd1;
            end
          end
        end
        S_DISCARD: begin
          if (w_nonempty) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Credit pulse one cycle after each pop; sticky overflow on a dropped push.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      credit_q <= w_pop;
      if (w_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_mask_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_mask_unpacker
// Summary  : Directed bench for tt_mask_unpacker; expected elements are
//            queued when words are supplied and compared as the DUT emits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_mask_unpacker;

  localparam int VLEN         = 256;
  localparam int MASK_CREDITS = 2;

  typedef struct packed {
    logic       mask;
    logic [7:0] idx;
    logic       last;
  } elem_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  vl = '0;
  logic [64:0] item = '0;
  logic        item_valid = 1'b0;
  logic        credit;
  logic        elem_valid;
  logic        elem_ready = 1'b0;
  logic        elem_mask;
  logic [7:0]  elem_idx;
  logic        elem_last;
  logic        busy;
  logic        overflow;

  int          errors = 0;
  int          checks = 0;
  int          credit_seen = 0;
  int          hs_cnt = 0;
  logic        exp_credit_pending = 1'b0;
  elem_t       sb [$];
  logic [63:0] exp_words [4];

  tt_mask_unpacker #(.VLEN(VLEN), .MASK_CREDITS(MASK_CREDITS)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_start          (start),
    .i_vl             (vl),
    .i_mask_idx_item  (item),
    .i_mask_idx_valid (item_valid),
    .o_mask_idx_credit(credit),
    .o_elem_valid     (elem_valid),
    .i_elem_ready     (elem_ready),
    .o_elem_mask      (elem_mask),
    .o_elem_idx       (elem_idx),
    .o_elem_last      (elem_last),
    .o_busy           (busy),
    .o_overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    vl    = 9'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic push_word(input logic [63:0] w);
    item_valid = 1'b1;
    item       = {1'b1, w};
    tick();
    item_valid = 1'b0;
    item       = '0;
  endtask

  // Model: element e of an op takes bit e%64 of word e/64.
  task automatic queue_expect(input int n_vl, input int n);
    elem_t x;
    for (int e = 0; e < n; e++) begin
      x.mask = exp_words[e / 64][e % 64];
      x.idx  = 8'(e);
      x.last = (e == n_vl - 1);
      sb.push_back(x);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n < budget), 64'd1);
    tick();
  endtask

  // Output monitor: every presented element must match the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      exp_credit_pending = 1'b0;
    end else begin
      if (exp_credit_pending) begin
        check("credit_timing", 64'(credit), 64'd1);
      end
      exp_credit_pending = 1'b0;
      if (credit) credit_seen++;
      if (elem_valid) begin
        check("unexpected_valid", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          check("elem", 64'({elem_mask, elem_idx, elem_last}), 64'(sb[0]));
          if (elem_ready) begin
            if (sb[0].idx[5:0] == 6'd63 || sb[0].last) exp_credit_pending = 1'b1;
            void'(sb.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    check("rst_valid", 64'(elem_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_credit", 64'(credit), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_outs", 64'({elem_mask, elem_idx, elem_last}), 64'd0);
    rst = 1'b0;
    tick();

    // vl=5, single word, free-flowing sink
    hs_cnt = 0; credit_seen = 0;
    exp_words[0] = 64'h15;
    elem_ready = 1'b1;
    do_start(5);
    check("t1_busy", 64'(busy), 64'd1);
    queue_expect(5, 5);
    push_word(exp_words[0]);
    @(negedge clk);
    check("t1_latency", 64'(elem_valid), 64'd1);
    wait_done(50);
    check("t1_hs", 64'(hs_cnt), 64'd5);
    check("t1_credits", 64'(credit_seen), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);

    // vl=130, three words, third sent once a credit returns
    hs_cnt = 0; credit_seen = 0;
    exp_words[0] = 64'h1;
    exp_words[1] = 64'h8000_0000_0000_0000;
    exp_words[2] = 64'h2;
    do_start(130);
    queue_expect(130, 130);
    push_word(exp_words[0]);
    push_word(exp_words[1]);
    n = 0;
    while (credit_seen < 1 && n < 200) begin
      tick();
      n++;
    end
    check("t2_credit_wait", 64'(n < 200), 64'd1);
    push_word(exp_words[2]);
    wait_done(300);
    check("t2_hs", 64'(hs_cnt), 64'd130);
    check("t2_credits", 64'(credit_seen), 64'd3);
    check("t2_overflow", 64'(overflow), 64'd0);

    // Backpressure: ready toggles every cycle
    hs_cnt = 0; credit_seen = 0;
    exp_words[0] = 64'h5;
    elem_ready = 1'b0;
    do_start(3);
    queue_expect(3, 3);
    push_word(exp_words[0]);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      elem_ready = ~elem_ready;
      tick();
      n++;
    end
    check("t3_timeout", 64'(n < 50), 64'd1);
    elem_ready = 1'b1;
    wait_done(20);
    check("t3_hs", 64'(hs_cnt), 64'd3);
    check("t3_credits", 64'(credit_seen), 64'd1);

    // vl=0: word is discarded, no element presented
    hs_cnt = 0; credit_seen = 0;
    do_start(0);
    check("t4_busy", 64'(busy), 64'd1);
    tick(); tick(); tick();
    push_word(64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(20);
    check("t4_hs", 64'(hs_cnt), 64'd0);
    check("t4_credits", 64'(credit_seen), 64'd1);
    check("t4_busy_end", 64'(busy), 64'd0);

    // Overflow: third push into a full FIFO is dropped
    hs_cnt = 0; credit_seen = 0;
    exp_words[0] = 64'hA5A5_0F0F_3C3C_9669;
    exp_words[1] = 64'h0123_4567_89AB_CDEF;
    exp_words[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    elem_ready = 1'b0;
    check("t5_ovf_before", 64'(overflow), 64'd0);
    do_start(200);
    queue_expect(200, 128);
    push_word(exp_words[0]);
    push_word(exp_words[1]);
    check("t5_ovf_full", 64'(overflow), 64'd0);
    push_word(exp_words[2]);
    check("t5_ovf_set", 64'(overflow), 64'd1);
    elem_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("t5_timeout", 64'(n < 300), 64'd1);
    tick(); tick(); tick(); tick();
    check("t5_hs", 64'(hs_cnt), 64'd128);
    check("t5_valid_stall", 64'(elem_valid), 64'd0);
    check("t5_busy_stuck", 64'(busy), 64'd1);
    check("t5_credits", 64'(credit_seen), 64'd2);
    check("t5_ovf_sticky", 64'(overflow), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("t5_ovf_cleared", 64'(overflow), 64'd0);
    check("t5_busy_cleared", 64'(busy), 64'd0);

    // Reset mid-RUN after 10 elements of vl=64
    hs_cnt = 0; credit_seen = 0;
    exp_words[0] = 64'hDEAD_BEEF_CAFE_F00D;
    do_start(64);
    queue_expect(64, 64);
    push_word(exp_words[0]);
    n = 0;
    while (hs_cnt < 10 && n < 100) begin
      tick();
      n++;
    end
    check("t6_timeout", 64'(n < 100), 64'd1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("t6_valid", 64'(elem_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_credit", 64'(credit), 64'd0);
    check("t6_hs", 64'(hs_cnt), 64'd10);
    tick();
    rst = 1'b0;
    tick();
    check("t6_credits", 64'(credit_seen), 64'd0);

    // Fresh vl=2 op after reset
    hs_cnt = 0; credit_seen = 0;
    exp_words[0] = 64'h2;
    do_start(2);
    queue_expect(2, 2);
    push_word(exp_words[0]);
    wait_done(20);
    check("t7_hs", 64'(hs_cnt), 64'd2);
    check("t7_credits", 64'(credit_seen), 64'd1);
    check("t7_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
